wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the core pipeline, sitting directly upstream of the register file's single write port. It merges two result streams, single-cycle ALU results and variable-latency load returns, into one registered write per cycle using round-robin arbitration. It also keeps a per-register pending-load scoreboard that decode uses to interlock reads of registers still waiting on a load.

## Interface
- DATA_W, default 32: register data width.
- ADDR_W, default 5: register address width; SIZE = 2**ADDR_W registers.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result offered.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU result accepted this cycle; combinational.
- ld_valid  in  1  load return offered.
- ld_rd  in  ADDR_W  load destination register.
- ld_data  in  DATA_W  load data.
- ld_ready  out  1  load return accepted this cycle; combinational.
- ld_issue  in  1  load issued by the memory stage; marks the destination pending.
- ld_issue_rd  in  ADDR_W  destination of the issued load.
- rf_wr  out  1  register-file write enable; registered.
- rf_addr_wr  out  ADDR_W  write address; registered.
- rf_data_wr  out  DATA_W  write data; registered.
- busy  out  SIZE  pending-load bit per register; registered; bit 0 is constant 0.
- ld_issue_err  out  1  one-cycle pulse when ld_issue targets an already-busy register.

## Operation
- Arbitration:
  - At most one source is accepted per cycle.
  - Only one source valid: that source is granted.
  - Both valid: grant goes to the source not granted most recently (`last_grant` register, reset value = LD, so the ALU wins the first tie).
  - `last_grant` updates only on a tie-broken grant.
  - `alu_ready` and `ld_ready` are derived combinationally from the valids and `last_grant` only. Neither depends on its own source's data.
  - Ready may be high while the corresponding valid is low; no acceptance occurs in that case.
- Write register:
  - On acceptance, `rf_addr_wr` and `rf_data_wr` load from the granted source.
  - `rf_wr` <= 1 if the granted rd != 0, else 0. Writes to r0 are consumed and discarded.
  - No acceptance: `rf_wr` <= 0; `rf_addr_wr` and `rf_data_wr` hold their values.
- Scoreboard:
  - busy[r] sets on a cycle with `ld_issue` and `ld_issue_rd` == r, for r != 0.
  - busy[r] clears on the edge where a load return with `ld_rd` == r is accepted.
  - Simultaneous set and clear of the same r: set wins, bit stays 1.
  - ALU writes never modify busy.
  - `ld_issue` to r with busy[r] = 1: bit stays 1 and `ld_issue_err` pulses the next cycle. Decode prevents this case; it is an error flag, not recovered.
  - `ld_issue` with rd 0: ignored, no error.
- No internal buffering; unaccepted sources hold their valid and data until accepted. This is an upstream requirement, not checked.

## Timing
- Reset values: `rf_wr` = 0, `rf_addr_wr` = 0, `rf_data_wr` = 0, busy = all 0, `ld_issue_err` = 0, `last_grant` = LD.
- Reset mid-operation clears all pending bits immediately (asynchronous) and drops any registered write.
- Latency:
  - Acceptance at edge E: `rf_wr` is high during cycle E..E+1, and the register file commits at E+1.
  - busy[r] falls after edge E. A decode read of r presented at E+1 hits the register file's write-through bypass and returns the new data.
- Throughput: one write per cycle.
- Fairness: with both sources continuously valid, grants alternate ALU, LD, ALU, LD, ...
- Busy reflects issue at edge E+1 after `ld_issue` sampled at E; no combinational path from `ld_issue` to busy.

## Test plan
- Reset, then ALU only: alu_valid=1, rd=3, data=0xDEADBEEF for one cycle -> alu_ready=1 that cycle; next cycle rf_wr=1, rf_addr_wr=3, rf_data_wr=0xDEADBEEF; following cycle rf_wr=0.
- Tie from reset: both valid for 4 cycles (ALU rd=1, LD rd=2) -> grants ALU, LD, ALU, LD; rf_addr_wr sequence 1, 2, 1, 2; never both ready in one cycle.
- Scoreboard: ld_issue rd=7 -> busy[7]=1 next cycle; later ld_valid rd=7 data=0x55 accepted -> busy[7]=0 and rf_wr=1, addr 7, data 0x55 in the same following cycle.
- Set/clear collision: busy[9]=1; in one cycle ld_issue rd=9 and an accepted ld return rd=9 -> busy[9] stays 1, ld_issue_err=0.
- r0 handling: ALU rd=0 accepted -> alu_ready=1, rf_wr stays 0; ld_issue rd=0 -> busy[0]=0, no error. Double issue rd=4 -> ld_issue_err pulses once.
- Async reset mid-stream: busy=0x0000_0090 and rf_wr=1, assert rst_n low between edges -> busy=0 and rf_wr=0 immediately, before the next edge.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: round-robin merge of ALU results and load returns into one
// registered register-file write per cycle, plus the pending-load scoreboard.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int SIZE = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_issue_rd,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_addr_wr,
  output logic [DATA_W-1:0] rf_data_wr,
  output logic [SIZE-1:0]   busy,
  output logic              ld_issue_err
);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LD  = 1'b1
  } grant_e;

  grant_e            last_grant_q;
  logic              rf_wr_q, rf_wr_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic [SIZE-1:0]   busy_q, busy_d;
  logic              err_q, err_d;
  logic              tie;
  logic              ld_accept_same_rd;

  // The winner of a tie is whichever source lost the previous tie.
  assign tie       = alu_valid && ld_valid;
  assign alu_ready = alu_valid && (!ld_valid || (last_grant_q == GRANT_LD));
  assign ld_ready  = ld_valid && (!alu_valid || (last_grant_q == GRANT_ALU));

  always_comb begin
    rf_wr_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (alu_ready) begin
      rf_wr_d   = (alu_rd != '0);
      rf_addr_d = alu_rd;
      rf_data_d = alu_data;
    end else if (ld_ready) begin
      rf_wr_d   = (ld_rd != '0);
      rf_addr_d = ld_rd;
      rf_data_d = ld_data;
    end
  end

  // Set is applied after clear so a same-register issue and return leaves it pending.
  assign ld_accept_same_rd = ld_ready && (ld_rd == ld_issue_rd);

  always_comb begin
    busy_d = busy_q;
    if (ld_ready) begin
      busy_d[ld_rd] = 1'b0;
    end
    if (ld_issue && (ld_issue_rd != '0)) begin
      busy_d[ld_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  assign err_d = ld_issue && (ld_issue_rd != '0) && busy_q[ld_issue_rd] && !ld_accept_same_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_LD;
      rf_wr_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      busy_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      if (tie) begin
        last_grant_q <= alu_ready ? GRANT_ALU : GRANT_LD;
      end
      rf_wr_q   <= rf_wr_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign rf_wr        = rf_wr_q;
  assign rf_addr_wr   = rf_addr_q;
  assign rf_data_wr   = rf_data_q;
  assign busy         = busy_q;
  assign ld_issue_err = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: arbitration, write register,
// scoreboard set/clear/error behaviour and asynchronous reset.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        rf_wr;
  logic [4:0]  rf_addr_wr;
  logic [31:0] rf_data_wr;
  logic [31:0] busy;
  logic        ld_issue_err;

  int nCompared = 0;
  int nMismatched = 0;

  wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .ld_valid     (ld_valid),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .ld_issue     (ld_issue),
    .ld_issue_rd  (ld_issue_rd),
    .rf_wr        (rf_wr),
    .rf_addr_wr   (rf_addr_wr),
    .rf_data_wr   (rf_data_wr),
    .busy         (busy),
    .ld_issue_err (ld_issue_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    ld_valid    = 1'b0;
    ld_rd       = '0;
    ld_data     = '0;
    ld_issue    = 1'b0;
    ld_issue_rd = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idleInputs();
    #2;
    nCompared++; if (rf_wr !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rf_wr: got %0h expected 0", rf_wr); end
    nCompared++; if (rf_addr_wr !== 5'd0) begin nMismatched++; $display("[TB] FAIL reset_rf_addr: got %0h expected 0", rf_addr_wr); end
    nCompared++; if (rf_data_wr !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_rf_data: got %0h expected 0", rf_data_wr); end
    nCompared++; if (busy !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
    nCompared++; if (ld_issue_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_err: got %0h expected 0", ld_issue_err); end
    nCompared++; if ({alu_ready, ld_ready} !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_ready: got %0b expected 00", {alu_ready, ld_ready}); end
    #10;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1;
    alu_rd    = 5'd3;
    alu_data  = 32'hDEADBEEF;
    #1;
    nCompared++; if ({alu_ready, ld_ready} !== 2'b10) begin nMismatched++; $display("[TB] FAIL alu_only_ready: got %0b expected 10", {alu_ready, ld_ready}); end
    step();
    idleInputs();
    nCompared++; if (rf_wr !== 1'b1) begin nMismatched++; $display("[TB] FAIL alu_only_wr: got %0h expected 1", rf_wr); end
    nCompared++; if (rf_addr_wr !== 5'd3) begin nMismatched++; $display("[TB] FAIL alu_only_addr: got %0h expected 3", rf_addr_wr); end
    nCompared++; if (rf_data_wr !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL alu_only_data: got %0h expected deadbeef", rf_data_wr); end
    step();
    nCompared++; if (rf_wr !== 1'b0) begin nMismatched++; $display("[TB] FAIL alu_only_wr_drop: got %0h expected 0", rf_wr); end
    nCompared++; if (rf_addr_wr !== 5'd3 || rf_data_wr !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL alu_only_hold: got %0h/%0h expected 3/deadbeef", rf_addr_wr, rf_data_wr); end
  endtask

  task automatic test_tie_fairness();
    logic expAlu;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1111_0001;
    ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 32'h2222_0002;
    expAlu = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      nCompared++; if ({alu_ready, ld_ready} !== {expAlu, ~expAlu}) begin nMismatched++; $display("[TB] FAIL tie_ready_%0d: got %0b expected %0b", i, {alu_ready, ld_ready}, {expAlu, ~expAlu}); end
      step();
      nCompared++; if (rf_wr !== 1'b1 || rf_addr_wr !== (expAlu ? 5'd1 : 5'd2) || rf_data_wr !== (expAlu ? 32'h1111_0001 : 32'h2222_0002)) begin
        nMismatched++; $display("[TB] FAIL tie_write_%0d: got wr=%0h addr=%0h data=%0h expected addr=%0h", i, rf_wr, rf_addr_wr, rf_data_wr, expAlu ? 5'd1 : 5'd2);
      end
      expAlu = ~expAlu;
    end
    idleInputs();
    step();
  endtask

  task automatic test_scoreboard();
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    step();
    idleInputs();
    nCompared++; if (busy !== 32'h0000_0080) begin nMismatched++; $display("[TB] FAIL sb_set: got %0h expected 80", busy); end
    step();
    nCompared++; if (busy !== 32'h0000_0080) begin nMismatched++; $display("[TB] FAIL sb_hold: got %0h expected 80", busy); end
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h55;
    #1;
    nCompared++; if ({alu_ready, ld_ready} !== 2'b01) begin nMismatched++; $display("[TB] FAIL sb_ld_ready: got %0b expected 01", {alu_ready, ld_ready}); end
    step();
    idleInputs();
    nCompared++; if (busy !== 32'd0) begin nMismatched++; $display("[TB] FAIL sb_clear: got %0h expected 0", busy); end
    nCompared++; if (rf_wr !== 1'b1 || rf_addr_wr !== 5'd7 || rf_data_wr !== 32'h55) begin nMismatched++; $display("[TB] FAIL sb_write: got wr=%0h addr=%0h data=%0h expected 1/7/55", rf_wr, rf_addr_wr, rf_data_wr); end
  endtask

  task automatic test_collision();
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    step();
    idleInputs();
    nCompared++; if (busy !== 32'h0000_0200) begin nMismatched++; $display("[TB] FAIL col_setup: got %0h expected 200", busy); end
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
    step();
    idleInputs();
    nCompared++; if (busy !== 32'h0000_0200) begin nMismatched++; $display("[TB] FAIL col_set_wins: got %0h expected 200", busy); end
    nCompared++; if (ld_issue_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL col_no_err: got %0h expected 0", ld_issue_err); end
    nCompared++; if (rf_wr !== 1'b1 || rf_addr_wr !== 5'd9 || rf_data_wr !== 32'h99) begin nMismatched++; $display("[TB] FAIL col_write: got wr=%0h addr=%0h data=%0h expected 1/9/99", rf_wr, rf_addr_wr, rf_data_wr); end
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h9A;
    step();
    idleInputs();
    nCompared++; if (busy !== 32'd0) begin nMismatched++; $display("[TB] FAIL col_final_clear: got %0h expected 0", busy); end
  endtask

  task automatic test_r0_and_double_issue();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    #1;
    nCompared++; if (alu_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL r0_alu_ready: got %0h expected 1", alu_ready); end
    step();
    idleInputs();
    nCompared++; if (rf_wr !== 1'b0) begin nMismatched++; $display("[TB] FAIL r0_no_write: got %0h expected 0", rf_wr); end
    ld_issue = 1'b1; ld_issue_rd = 5'd0;
    step();
    ld_issue = 1'b1; ld_issue_rd = 5'd0;
    step();
    idleInputs();
    nCompared++; if (busy !== 32'd0 || ld_issue_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL r0_issue: got busy=%0h err=%0h expected 0/0", busy, ld_issue_err); end
    ld_issue = 1'b1; ld_issue_rd = 5'd4;
    step();
    nCompared++; if (busy !== 32'h10 || ld_issue_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL dbl_first: got busy=%0h err=%0h expected 10/0", busy, ld_issue_err); end
    step();
    idleInputs();
    nCompared++; if (ld_issue_err !== 1'b1) begin nMismatched++; $display("[TB] FAIL dbl_err_pulse: got %0h expected 1", ld_issue_err); end
    step();
    nCompared++; if (ld_issue_err !== 1'b0 || busy !== 32'h10) begin nMismatched++; $display("[TB] FAIL dbl_err_end: got err=%0h busy=%0h expected 0/10", ld_issue_err, busy); end
  endtask

  task automatic test_async_reset();
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hABCD;
    step();
    idleInputs();
    nCompared++; if (busy !== 32'h0000_0090 || rf_wr !== 1'b1) begin nMismatched++; $display("[TB] FAIL ar_setup: got busy=%0h wr=%0h expected 90/1", busy, rf_wr); end
    #2;
    rst_n = 1'b0;
    #1;
    nCompared++; if (busy !== 32'd0) begin nMismatched++; $display("[TB] FAIL ar_busy: got %0h expected 0", busy); end
    nCompared++; if (rf_wr !== 1'b0 || rf_addr_wr !== 5'd0 || rf_data_wr !== 32'd0) begin nMismatched++; $display("[TB] FAIL ar_write: got wr=%0h addr=%0h data=%0h expected 0/0/0", rf_wr, rf_addr_wr, rf_data_wr); end
    #2;
    rst_n = 1'b1;
    step();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 32'h2;
    #1;
    nCompared++; if ({alu_ready, ld_ready} !== 2'b10) begin nMismatched++; $display("[TB] FAIL ar_tie_alu_first: got %0b expected 10", {alu_ready, ld_ready}); end
    step();
    idleInputs();
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_tie_fairness();
    test_scoreboard();
    test_collision();
    test_r0_and_double_issue();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
